// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART ALU datapath: response opcodes,
// response header size and the response framer state encoding.
package uart_alu_pkg;

   localparam logic [7:0] OP_ADD = 8'hEC;
   localparam logic [7:0] OP_MUL = 8'hED;
   localparam logic [7:0] OP_DIV = 8'hEE;

   // opcode, reserved zero byte, 16-bit little-endian length
   localparam int RSP_HDR_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      CKSUM = 2'd2
   } rsp_state_t;

endpackage

// File: rtl/uart_rsp_framer.sv
// Response framer: takes one result word + opcode in a single handshake and
// streams a fixed-length byte packet to the UART transmitter.
// Packet: opcode, 8'h00, LEN[7:0], LEN[15:8], result bytes LSB first.
// Optional build macro UART_RSP_CHECKSUM_EN appends an 8-bit additive
// checksum byte (and counts it in LEN).
module uart_rsp_framer
   import uart_alu_pkg::*;
#(
   parameter int datawidth_p = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [datawidth_p-1:0] result_i,
   input  logic [7:0]             opcode_i,
   input  logic                   valid_i,
   output logic                   ready_o,
   output logic [7:0]             tx_data_o,
   output logic                   tx_valid_o,
   input  logic                   tx_ready_i,
   output logic                   busy_o
);

   localparam int NB = datawidth_p / 8;
`ifdef UART_RSP_CHECKSUM_EN
   localparam int LEN       = RSP_HDR_BYTES + NB + 1;
   localparam int LAST_DATA = LEN - 2;   // checksum byte follows
`else
   localparam int LEN       = RSP_HDR_BYTES + NB;
   localparam int LAST_DATA = LEN - 1;
`endif
   localparam int          CW    = $clog2(LEN + 2);
   localparam logic [15:0] LEN16 = 16'(LEN);

   rsp_state_t             state, state_n;
   logic [CW-1:0]          cnt, cnt_n;
   logic [datawidth_p-1:0] res_q, res_n;
   logic [7:0]             op_q, op_n;
   logic [7:0]             data_q, data_n;
   logic                   vld_q, vld_n;
   logic                   rdy_q, rdy_n;
   logic                   busy_q, busy_n;
   logic                   tx_hs;
`ifdef UART_RSP_CHECKSUM_EN
   logic [7:0]             sum_q, sum_n;
`endif

   assign tx_hs      = vld_q && tx_ready_i;
   assign ready_o    = rdy_q;
   assign tx_data_o  = data_q;
   assign tx_valid_o = vld_q;
   assign busy_o     = busy_q;

   // Counter-indexed byte mux over the captured opcode/result.
   function automatic logic [7:0] pick(input logic [CW-1:0] idx,
                                       input logic [7:0] op,
                                       input logic [datawidth_p-1:0] res);
      logic [7:0] b;
      b = 8'h00;
      case (int'(idx))
         0:       b = op;
         1:       b = 8'h00;
         2:       b = LEN16[7:0];
         3:       b = LEN16[15:8];
         default: begin
            for (int i = 0; i < NB; i++)
               if (int'(idx) == RSP_HDR_BYTES + i) b = res[i*8 +: 8];
         end
      endcase
      return b;
   endfunction

   // State and datapath registers; reset drops any packet in flight.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state  <= IDLE;
         cnt    <= '0;
         res_q  <= '0;
         op_q   <= '0;
         data_q <= '0;
         vld_q  <= 1'b0;
         rdy_q  <= 1'b0;
         busy_q <= 1'b0;
`ifdef UART_RSP_CHECKSUM_EN
         sum_q  <= '0;
`endif
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         res_q  <= res_n;
         op_q   <= op_n;
         data_q <= data_n;
         vld_q  <= vld_n;
         rdy_q  <= rdy_n;
         busy_q <= busy_n;
`ifdef UART_RSP_CHECKSUM_EN
         sum_q  <= sum_n;
`endif
      end
   end

   // Next-state logic; outputs are registered so they hold under backpressure.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      res_n   = res_q;
      op_n    = op_q;
      data_n  = data_q;
      vld_n   = vld_q;
      rdy_n   = rdy_q;
      busy_n  = busy_q;
`ifdef UART_RSP_CHECKSUM_EN
      sum_n   = sum_q;
`endif
      case (state)
         IDLE: begin
            rdy_n  = 1'b1;
            vld_n  = 1'b0;
            busy_n = 1'b0;
            cnt_n  = '0;
`ifdef UART_RSP_CHECKSUM_EN
            sum_n  = '0;
`endif
            if (valid_i && rdy_q) begin
               res_n   = result_i;
               op_n    = opcode_i;
               data_n  = opcode_i;
               vld_n   = 1'b1;
               busy_n  = 1'b1;
               rdy_n   = 1'b0;
               state_n = SEND;
            end
         end
         SEND: begin
            rdy_n = 1'b0;
            if (tx_hs) begin
`ifdef UART_RSP_CHECKSUM_EN
               sum_n = sum_q + data_q;
`endif
               if (cnt == CW'(LAST_DATA)) begin
`ifdef UART_RSP_CHECKSUM_EN
                  data_n  = sum_q + data_q;
                  cnt_n   = cnt + CW'(1);
                  state_n = CKSUM;
`else
                  vld_n   = 1'b0;
                  busy_n  = 1'b0;
                  rdy_n   = 1'b1;
                  cnt_n   = '0;
                  state_n = IDLE;
`endif
               end else begin
                  cnt_n  = cnt + CW'(1);
                  data_n = pick(cnt + CW'(1), op_q, res_q);
               end
            end
         end
`ifdef UART_RSP_CHECKSUM_EN
         CKSUM: begin
            rdy_n = 1'b0;
            if (tx_hs) begin
               vld_n   = 1'b0;
               busy_n  = 1'b0;
               rdy_n   = 1'b1;
               cnt_n   = '0;
               state_n = IDLE;
            end
         end
`endif
         default: begin
            vld_n   = 1'b0;
            busy_n  = 1'b0;
            rdy_n   = 1'b0;
            cnt_n   = '0;
            state_n = IDLE;
         end
      endcase
   end

endmodule
